// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler and its
// hardware checksum reporter.
package uart_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN_CPU,
      OWN_RPT
   } arb_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_SEND,
      R_DONE
   } rpt_state_t;

   localparam int          REPORT_LEN = 18;
   localparam logic [63:0] PREFIX     = "Result: ";
   localparam logic [7:0]  LF         = 8'h0A;
   localparam logic [7:0]  CR         = 8'h0D;

   // Lowercase hex digit.
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

endpackage

// File: rtl/hex_report_gen.sv
// Emits "Result: xxxxxxxx\r\n" for a non-zero tohost CSR write, one byte per
// accepted handshake on a valid/ready byte port.
module hex_report_gen
   import uart_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_we,
   input  logic [31:0] csr_wdata,
   output logic        valid,
   output logic [7:0]  data,
   input  logic        ready,
   output logic        busy,
   output logic        done
);

   rpt_state_t  state;
   logic [31:0] value;
   logic [4:0]  idx;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= R_IDLE;
         value <= '0;
         idx   <= '0;
         done  <= 1'b0;
      end else begin
         case (state)
            R_IDLE, R_DONE: begin
               if (csr_we && csr_wdata != '0) begin
                  value <= csr_wdata;
                  idx   <= '0;
                  done  <= 1'b0;
                  state <= R_SEND;
               end
            end
            R_SEND: begin
               // Writes arriving mid-report are dropped; the latched value stays.
               if (ready) begin
                  if (idx == 5'(REPORT_LEN - 1)) begin
                     idx   <= '0;
                     done  <= 1'b1;
                     state <= R_DONE;
                  end else begin
                     idx <= idx + 5'd1;
                  end
               end
            end
            default: state <= R_IDLE;
         endcase
      end
   end

   assign busy  = (state == R_SEND);
   assign valid = busy;

   // NOTE: data gets a default before the branches so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      data = LF;
      if (idx < 5'd8) begin
         data = PREFIX[{3'd7 - idx[2:0], 3'b000} +: 8];
      end else if (idx < 5'd16) begin
         data = nibble_to_ascii(value[{3'd7 - idx[2:0], 2'b00} +: 4]);
      end else if (idx == 5'd16) begin
         data = CR;
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Line-locked arbiter sharing one UART transmitter between the CPU MMIO byte
// path and the hardware checksum reporter.
module uart_tx_sched
   import uart_sched_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_tx_valid,
   input  logic [7:0]  cpu_tx_data,
   output logic        cpu_tx_ready,
   input  logic        csr_we,
   input  logic [31:0] csr_wdata,
   output logic        uart_tx_valid,
   output logic [7:0]  uart_tx_data,
   input  logic        uart_tx_ready,
   output logic        report_busy,
   output logic        report_done
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_t    state;
   logic          last_rpt;
   logic [CW-1:0] idle_cnt;
   logic          pend_valid;
   logic          pend_rpt;

   logic       rpt_valid;
   logic [7:0] rpt_data;
   logic       rpt_ready;
   logic       grant_cpu;
   logic       grant_rpt;
   logic       accept;
   logic       accept_lf;

   hex_report_gen u_report (
      .clk       (clk),
      .rst_n     (rst_n),
      .csr_we    (csr_we),
      .csr_wdata (csr_wdata),
      .valid     (rpt_valid),
      .data      (rpt_data),
      .ready     (rpt_ready),
      .busy      (report_busy),
      .done      (report_done)
   );

   // A byte left hanging in IDLE keeps its grant, so a late second requester
   // cannot swap the presented byte under the transmitter.
   always_comb begin
      grant_cpu = 1'b0;
      grant_rpt = 1'b0;
      case (state)
         OWN_CPU: grant_cpu = 1'b1;
         OWN_RPT: grant_rpt = 1'b1;
         default: begin
            if (pend_valid) begin
               grant_rpt = pend_rpt;
               grant_cpu = ~pend_rpt;
            end else if (cpu_tx_valid && rpt_valid) begin
               grant_rpt = ~last_rpt;
               grant_cpu = last_rpt;
            end else begin
               grant_cpu = cpu_tx_valid;
               grant_rpt = rpt_valid;
            end
         end
      endcase
   end

   assign uart_tx_valid = (grant_cpu & cpu_tx_valid) | (grant_rpt & rpt_valid);
   assign uart_tx_data  = grant_cpu ? cpu_tx_data : (grant_rpt ? rpt_data : 8'h00);
   assign cpu_tx_ready  = uart_tx_ready & grant_cpu;
   assign rpt_ready     = uart_tx_ready & grant_rpt;
   assign accept        = uart_tx_valid & uart_tx_ready;
   assign accept_lf     = accept && (uart_tx_data == LF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_rpt   <= 1'b0;
         idle_cnt   <= '0;
         pend_valid <= 1'b0;
         pend_rpt   <= 1'b0;
      end else begin
         pend_valid <= uart_tx_valid & ~uart_tx_ready;
         pend_rpt   <= grant_rpt;
         if (accept) last_rpt <= grant_rpt;
         case (state)
            IDLE: begin
               idle_cnt <= '0;
               // A lone LF is a complete line, so it does not take the lock.
               if (accept && !accept_lf) state <= grant_rpt ? OWN_RPT : OWN_CPU;
            end
            OWN_CPU: begin
               if (accept) begin
                  idle_cnt <= '0;
                  if (accept_lf) state <= IDLE;
               end else begin
                  // The counter reaches TIMEOUT_CYCLES-1 on the edge the lock drops.
                  idle_cnt <= idle_cnt + 1'b1;
                  if (idle_cnt == CW'(TIMEOUT_CYCLES - 2)) state <= IDLE;
               end
            end
            OWN_RPT: begin
               if (accept_lf) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a byte-stream scoreboard built from the
// expected text lines plus cycle-exact checks of latency, lock and reset.
module tb_uart_tx_sched;

   logic        clk;
   logic        rst_n;
   logic        cpu_tx_valid;
   logic [7:0]  cpu_tx_data;
   logic        cpu_tx_ready;
   logic        csr_we;
   logic [31:0] csr_wdata;
   logic        uart_tx_valid;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_ready;
   logic        report_busy;
   logic        report_done;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_byte;
   logic        toggle_mode = 1'b0;

   uart_tx_sched #(.TIMEOUT_CYCLES(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpu_tx_valid  (cpu_tx_valid),
      .cpu_tx_data   (cpu_tx_data),
      .cpu_tx_ready  (cpu_tx_ready),
      .csr_we        (csr_we),
      .csr_wdata     (csr_wdata),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_ready (uart_tx_ready),
      .report_busy   (report_busy),
      .report_done   (report_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   task automatic push_report(input logic [31:0] v);
      push_str($sformatf("Result: %08x", v));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic csr_write(input logic [31:0] v);
      csr_we    = 1'b1;
      csr_wdata = v;
      @(posedge clk); #1;
      csr_we    = 1'b0;
   endtask

   task automatic cpu_send(input logic [7:0] b, input string name);
      logic got;
      got          = 1'b0;
      cpu_tx_valid = 1'b1;
      cpu_tx_data  = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cpu_tx_ready) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      cpu_tx_valid = 1'b0;
      cpu_tx_data  = 8'h00;
      check(name, {31'd0, got}, 32'd1);
   endtask

   task automatic wait_done(input string name, input int budget);
      logic got;
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (report_done) begin
            got = 1'b1;
            break;
         end
      end
      check(name, {31'd0, got}, 32'd1);
      @(posedge clk); #1;
   endtask

   // Scoreboard: every accepted byte must be the next one of the expected text.
   always @(negedge clk) begin
      if (rst_n && uart_tx_valid && uart_tx_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_extra: got %0h expected no byte", uart_tx_data);
         end else begin
            exp_byte = exp_q.pop_front();
            if (uart_tx_data !== exp_byte) begin
               errors++;
               $display("FAIL stream_byte: got %0h expected %0h", uart_tx_data, exp_byte);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (toggle_mode) uart_tx_ready = ~uart_tx_ready;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      int first;
      rst_n         = 1'b0;
      cpu_tx_valid  = 1'b0;
      cpu_tx_data   = 8'h00;
      csr_we        = 1'b0;
      csr_wdata     = '0;
      uart_tx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_valid", {31'd0, uart_tx_valid}, 32'd0);
      check("rst_data",  {24'd0, uart_tx_data},  32'd0);
      check("rst_cpu_ready", {31'd0, cpu_tx_ready}, 32'd0);
      check("rst_busy",  {31'd0, report_busy},   32'd0);
      check("rst_done",  {31'd0, report_done},   32'd0);
      @(posedge clk); #1;

      // Basic report, back-to-back
      uart_tx_ready = 1'b1;
      push_report(32'h00C0FFEE);
      csr_write(32'h00C0FFEE);
      bad = 0;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (!(uart_tx_valid && report_busy) || report_done) bad++;
         if (i == 0)  check("first_byte_R", {24'd0, uart_tx_data}, 32'h52);
         if (i == 10) check("byte10_c",     {24'd0, uart_tx_data}, 32'h63);
         if (i == 16) check("byte16_cr",    {24'd0, uart_tx_data}, 32'h0D);
      end
      check("burst_busy_cycles", bad, 0);
      @(negedge clk);
      check("basic_done", {31'd0, report_done}, 32'd1);
      check("basic_idle_busy", {31'd0, report_busy}, 32'd0);
      check("basic_stream_empty", exp_q.size(), 0);
      @(posedge clk); #1;

      // Ignored writes: zero data, and a write mid-report
      csr_write(32'h0);
      @(negedge clk);
      check("zero_write_busy", {31'd0, report_busy}, 32'd0);
      check("zero_write_done", {31'd0, report_done}, 32'd1);
      @(posedge clk); #1;
      push_report(32'h3);
      csr_write(32'h3);
      repeat (4) @(posedge clk);
      #1;
      csr_write(32'h5);
      wait_done("ign_done", 60);
      repeat (5) @(negedge clk);
      check("ign_no_second", {31'd0, report_busy}, 32'd0);
      check("ign_stream_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      push_report(32'h7);
      csr_write(32'h7);
      @(negedge clk);
      check("restart_done_clr", {31'd0, report_done}, 32'd0);
      check("restart_busy", {31'd0, report_busy}, 32'd1);
      @(posedge clk); #1;
      wait_done("restart_done", 60);
      check("restart_stream_empty", exp_q.size(), 0);

      // Line lock with toggling ready
      push_str("ab");
      exp_q.push_back(8'h0A);
      push_report(32'h1);
      toggle_mode = 1'b1;
      cpu_send("a", "lock_a");
      csr_write(32'h1);
      cpu_send("b", "lock_b");
      cpu_send(8'h0A, "lock_lf");
      wait_done("lock_done", 100);
      toggle_mode = 1'b0;
      @(posedge clk); #2;
      uart_tx_ready = 1'b1;
      @(posedge clk); #1;
      check("lock_stream_empty", exp_q.size(), 0);

      // CPU lock timeout: reporter first byte 16 cycles after "x"
      push_str("x");
      push_report(32'h2);
      cpu_send("x", "tmo_x");
      csr_write(32'h2);
      first = 0;
      for (int j = 2; j < 40; j++) begin
         @(negedge clk);
         if (uart_tx_valid) begin
            first = j;
            break;
         end
      end
      check("timeout_latency", first, 16);
      @(posedge clk); #1;
      wait_done("tmo_done", 60);
      check("tmo_stream_empty", exp_q.size(), 0);

      // Asynchronous reset mid-report
      push_str("Resul");
      csr_write(32'hDEADBEEF);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, uart_tx_valid}, 32'd0);
      check("arst_data",  {24'd0, uart_tx_data},  32'd0);
      check("arst_cpu_ready", {31'd0, cpu_tx_ready}, 32'd0);
      check("arst_busy",  {31'd0, report_busy},   32'd0);
      check("arst_done",  {31'd0, report_done},   32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (uart_tx_valid || report_busy || report_done) bad++;
      end
      check("arst_silent_cycles", bad, 0);
      check("arst_stream_empty", exp_q.size(), 0);
      @(posedge clk); #1;

      // Backpressure with both sources requesting; reporter wins first tie
      uart_tx_ready = 1'b0;
      push_report(32'hA5);
      push_str("z");
      csr_write(32'hA5);
      cpu_tx_valid = 1'b1;
      cpu_tx_data  = "z";
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!uart_tx_valid || uart_tx_data !== 8'h52 || cpu_tx_ready) bad++;
      end
      check("bp_hold_cycles", bad, 0);
      @(posedge clk); #1;
      uart_tx_ready = 1'b1;
      cpu_send("z", "bp_cpu_after");
      repeat (2) @(posedge clk);
      #1;
      check("bp_done", {31'd0, report_done}, 32'd1);
      check("bp_stream_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
